branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
- Next-generation branch unit for the RV32I pipeline, parametrised in XLEN and predictor depth.
- Fetch side: direction prediction from a bimodal branch history table (BHT) of 2-bit saturating counters.
- EX side: resolves conditional branches, computes the target, and trains the BHT. On a mispredict it raises a registered one-cycle flush with the redirect PC.
- Sits between IF (prediction) and EX (resolution); its flush output drives the pipeline squash logic.

Parameters:
- XLEN, 32, datapath / PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, at least 2.
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch PC valid.
- if_pc  in  XLEN  fetch PC.
- if_pred_taken  out  1  predicted direction for if_pc.
- ex_valid  in  1  EX-stage instruction valid.
- ex_opcode  in  7  EX opcode.
- ex_funct3  in  3  EX funct3.
- ex_rs1  in  XLEN  forwarded rs1 value.
- ex_rs2  in  XLEN  forwarded rs2 value.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  13  B-type immediate, bit 0 = 0.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_taken  out  1  combinational resolved direction.
- flush  out  1  registered one-cycle mispredict flush.
- redirect_pc  out  XLEN  registered correct next PC; valid while flush = 1.

Behaviour:
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1:2].
- Prediction (combinational): if_pred_taken = if_valid & bht[idx(if_pc)][1].
- Branch qualifier: is_br = ex_valid & ~flush & (ex_opcode == 7'b1100011).
  - An EX instruction presented in the cycle flush = 1 is wrong-path. It is ignored: no update, no flush.
- funct3 decode:
  - 000 BEQ: taken when equal.
  - 001 BNE: taken when not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010, 011: taken = 0, BHT not updated, mispredict still evaluated.
- ex_taken = is_br & cond. When is_br = 0, ex_taken = 0.
- Target: ex_pc + sign_extend(ex_imm) to XLEN, modulo 2^XLEN (wraps silently). Fall-through: ex_pc + 4, also wrapping.
- Mispredict: is_br & (ex_taken != ex_pred_taken).
  - Next edge: flush <= 1; redirect_pc <= ex_taken ? target : ex_pc + 4.
  - Otherwise flush <= 0; redirect_pc holds its last value.
  - Latency: 1 cycle from EX to flush.
- BHT update on is_br with a legal funct3:
  - Taken: counter saturates upward at 2'b11.
  - Not taken: counter saturates downward at 2'b00.
  - Written on the same edge as flush.
- Same-cycle read/write of the same index: the prediction returns the pre-update value (no bypass).
- Reset (asynchronous, any time, including mid-flush): flush = 0, redirect_pc = 0, every BHT entry = CTR_INIT.
  - The first prediction after reset is not-taken.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds outputs stat_branches (32-bit) and stat_mispredicts (32-bit).
  - stat_branches increments on every is_br.
  - stat_mispredicts increments on every mispredict.
  - Both are free-running, wrap at 2^32, and clear on reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - OPC_BRANCH constant.
  - F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU constants.
  - bht_ctr_t typedef (2-bit).
  - Counter constants SNT, WNT, WT, ST.
- One combinational sub-module, branch_cmp: inputs funct3, rs1, rs2; outputs cond and legal.
- Table, update logic and flush registers stay in the top module.

Test Plan:
- Reset, then if_pc = 0x100 -> if_pred_taken = 0. Next, BEQ rs1 = rs2 = 5, ex_pc = 0x100, imm = +16, pred = 0 -> next cycle flush = 1, redirect_pc = 0x110, counter = 2'b10.
- BLT vs BLTU with rs1 = 0xFFFFFFFF, rs2 = 1 -> BLT taken, BLTU not taken. Same sign split for BGE = 0 and BGEU = 1.
- Correct prediction: BNE with 3 vs 3, pred = 0 -> flush stays 0, counter decremented, saturating at 2'b00 after repeats.
- Four taken branches at one index -> counter saturates at 2'b11. A not-taken with pred = 1 -> flush, redirect_pc = ex_pc + 4, counter = 2'b10.
- Squash: mispredict, then a valid branch in the flush cycle -> no second flush, no BHT change.
- Wrap and reset: ex_pc = 0xFFFFFFF8, imm = +8 taken -> redirect_pc = 0x0. Assert rst_n low while flush = 1 -> flush drops immediately, table back to CTR_INIT. With BRANCH_STATS_EN, both stat counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared RV32I branch encodings and bimodal counter helpers for branch_predict_resolve.
package branch_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t SNT = 2'b00;
   localparam bht_ctr_t WNT = 2'b01;
   localparam bht_ctr_t WT  = 2'b10;
   localparam bht_ctr_t ST  = 2'b11;

   // Two-bit saturating step toward the resolved direction.
   function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
      if (taken) return (ctr == ST)  ? ST  : bht_ctr_t'(ctr + 2'd1);
      else       return (ctr == SNT) ? SNT : bht_ctr_t'(ctr - 2'd1);
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: decodes funct3 into a taken condition and a legality flag.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            cond,
   output logic            legal
);

   logic eq, lt, ltu;

   assign eq  = (rs1 == rs2);
   assign lt  = ($signed(rs1) < $signed(rs2));
   assign ltu = (rs1 < rs2);

   always_comb begin
      // NOTE: defaults up front keep every path assigned, so no latch is inferred.
      cond  = 1'b0;
      legal = 1'b1;
      unique case (funct3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = ~eq;
         F3_BLT:  cond = lt;
         F3_BGE:  cond = ~lt;
         F3_BLTU: cond = ltu;
         F3_BGEU: cond = ~ltu;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal BHT predictor plus EX-stage branch resolution with registered mispredict flush.
// Optional feature: define BRANCH_STATS_EN to add stat_branches / stat_mispredicts counters.
module branch_predict_resolve
   import branch_pkg::*;
#(
   parameter int       XLEN      = 32,
   parameter int       BHT_DEPTH = 64,
   parameter bht_ctr_t CTR_INIT  = WNT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [12:0]     ex_imm,
   input  logic            ex_pred_taken,
   output logic            ex_taken,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   bht_ctr_t        bht [BHT_DEPTH];
   logic [IDX_W-1:0] if_idx, ex_idx;
   logic            cond, legal, is_br, mispredict;
   logic [XLEN-1:0] target, fall_thru;
   logic            unused_if_pc;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

   assign if_pred_taken = if_valid & bht[if_idx][1];

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .funct3 (ex_funct3),
      .rs1    (ex_rs1),
      .rs2    (ex_rs2),
      .cond   (cond),
      .legal  (legal)
   );

   // Anything in EX during the flush cycle is wrong-path and must not resolve.
   assign is_br      = ex_valid & ~flush & (ex_opcode == OPC_BRANCH);
   assign ex_taken   = is_br & cond;
   assign mispredict = is_br & (ex_taken != ex_pred_taken);
   assign target     = ex_pc + {{(XLEN-13){ex_imm[12]}}, ex_imm};
   assign fall_thru  = ex_pc + XLEN'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush       <= 1'b0;
         redirect_pc <= '0;
         // NOTE: the table is reset entry by entry (flops, not a RAM) so the first prediction is known.
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
`ifdef BRANCH_STATS_EN
         stat_branches    <= '0;
         stat_mispredicts <= '0;
`endif
      end else begin
         flush <= mispredict;
         if (mispredict) redirect_pc <= ex_taken ? target : fall_thru;
         if (is_br && legal) bht[ex_idx] <= ctr_next(bht[ex_idx], ex_taken);
`ifdef BRANCH_STATS_EN
         if (is_br)      stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
`endif
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve: vector table plus flush/squash/wrap/reset sequences.
module tb_branch_predict_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1, ex_rs2, ex_pc;
   logic [12:0] ex_imm;
   logic        ex_pred_taken;
   logic        ex_taken;
   logic        flush;
   logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   branch_predict_resolve dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .ex_valid      (ex_valid),
      .ex_opcode     (ex_opcode),
      .ex_funct3     (ex_funct3),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .ex_pred_taken (ex_pred_taken),
      .ex_taken      (ex_taken),
      .flush         (flush),
      .redirect_pc   (redirect_pc)
`ifdef BRANCH_STATS_EN
     ,.stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] ALU = 7'b0110011;

   typedef struct {
      logic        valid;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] rs1, rs2, pc;
      logic [12:0] imm;
      logic        pred;
      logic        ifv;
      logic        exp_ifp;
      logic        exp_taken;
      logic        exp_flush;
      logic [31:0] exp_redir;
      logic [1:0]  exp_ctr;
   } vec_t;

   typedef struct {
      logic        flush;
      logic [31:0] redir;
      logic [5:0]  idx;
      logic [1:0]  ctr;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned m_branches = 0;
   int unsigned m_misp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic valid, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                               input logic [12:0] imm, input logic pred, input logic ifv,
                               input logic exp_ifp, input logic exp_taken, input logic exp_flush,
                               input logic [31:0] exp_redir, input logic [1:0] exp_ctr);
      vec_t v;
      v.valid = valid; v.opc = opc; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc;
      v.imm = imm; v.pred = pred; v.ifv = ifv; v.exp_ifp = exp_ifp; v.exp_taken = exp_taken;
      v.exp_flush = exp_flush; v.exp_redir = exp_redir; v.exp_ctr = exp_ctr;
      return v;
   endfunction

   task automatic drive_ex(input logic valid, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                           input logic [12:0] imm, input logic pred);
      ex_valid = valid; ex_opcode = opc; ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2;
      ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " flush"}, flush, e.flush);
         check({tag, " redirect_pc"}, redirect_pc, e.redir);
         check({tag, " ctr"}, dut.bht[e.idx], e.ctr);
      end
   endtask

   task automatic idle_cycle(input string tag);
      drive_ex(1'b0, 7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
      @(posedge clk); #1;
      check({tag, " flush clears"}, flush, 1'b0);
   endtask

   task automatic apply(input vec_t v, input int n);
      string tag;
      exp_t  e;
      tag = $sformatf("vec%0d", n);
      @(negedge clk);
      drive_ex(v.valid, v.opc, v.f3, v.rs1, v.rs2, v.pc, v.imm, v.pred);
      if_valid = v.ifv; if_pc = v.pc;
      #1;
      check({tag, " if_pred_taken"}, if_pred_taken, v.exp_ifp);
      check({tag, " ex_taken"}, ex_taken, v.exp_taken);
      e.flush = v.exp_flush; e.redir = v.exp_redir; e.idx = v.pc[7:2]; e.ctr = v.exp_ctr;
      sb.push_back(e);
      if (v.valid && v.opc == BR) m_branches++;
      if (v.exp_flush) m_misp++;
      @(posedge clk); #1;
      pop_check(tag);
      idle_cycle(tag);
   endtask

   vec_t vecs[17];

   initial begin
      vecs[0]  = mk(1, BR,  3'b000, 32'd5,        32'd5, 32'h100,      13'h010,  0, 1, 0, 1, 1, 32'h110,  2'b10);
      vecs[1]  = mk(1, BR,  3'b100, 32'hFFFFFFFF, 32'd1, 32'h204,      13'h000,  1, 1, 0, 1, 0, 32'h110,  2'b10);
      vecs[2]  = mk(1, BR,  3'b110, 32'hFFFFFFFF, 32'd1, 32'h208,      13'h000,  0, 1, 0, 0, 0, 32'h110,  2'b00);
      vecs[3]  = mk(1, BR,  3'b101, 32'hFFFFFFFF, 32'd1, 32'h20C,      13'h000,  1, 1, 0, 0, 1, 32'h210,  2'b00);
      vecs[4]  = mk(1, BR,  3'b111, 32'hFFFFFFFF, 32'd1, 32'h210,      13'h000,  1, 1, 0, 1, 0, 32'h210,  2'b10);
      vecs[5]  = mk(1, BR,  3'b001, 32'd3,        32'd3, 32'h214,      13'h000,  0, 1, 0, 0, 0, 32'h210,  2'b00);
      vecs[6]  = mk(1, BR,  3'b001, 32'd3,        32'd3, 32'h214,      13'h000,  0, 1, 0, 0, 0, 32'h210,  2'b00);
      vecs[7]  = mk(1, BR,  3'b010, 32'd3,        32'd3, 32'h218,      13'h000,  1, 1, 0, 0, 1, 32'h21C,  2'b01);
      vecs[8]  = mk(1, BR,  3'b011, 32'd3,        32'd3, 32'h218,      13'h000,  0, 1, 0, 0, 0, 32'h21C,  2'b01);
      vecs[9]  = mk(1, ALU, 3'b000, 32'd3,        32'd3, 32'h21C,      13'h000,  1, 1, 0, 0, 0, 32'h21C,  2'b01);
      vecs[10] = mk(0, BR,  3'b000, 32'd3,        32'd3, 32'h21C,      13'h000,  1, 1, 0, 0, 0, 32'h21C,  2'b01);
      vecs[11] = mk(1, BR,  3'b000, 32'd7,        32'd7, 32'h220,      13'h1FF8, 0, 1, 0, 1, 1, 32'h218,  2'b10);
      vecs[12] = mk(1, BR,  3'b000, 32'd7,        32'd7, 32'h220,      13'h1FF8, 1, 1, 1, 1, 0, 32'h218,  2'b11);
      vecs[13] = mk(1, BR,  3'b000, 32'd7,        32'd7, 32'h220,      13'h1FF8, 1, 0, 0, 1, 0, 32'h218,  2'b11);
      vecs[14] = mk(1, BR,  3'b000, 32'd7,        32'd7, 32'h220,      13'h1FF8, 1, 1, 1, 1, 0, 32'h218,  2'b11);
      vecs[15] = mk(1, BR,  3'b000, 32'd7,        32'd8, 32'h220,      13'h1FF8, 1, 1, 1, 0, 1, 32'h224,  2'b10);
      vecs[16] = mk(1, BR,  3'b001, 32'd1,        32'd1, 32'hFFFFFFFC, 13'h000,  1, 1, 0, 0, 1, 32'h0,    2'b00);

      rst_n = 1'b0;
      if_valid = 1'b0; if_pc = '0;
      drive_ex(1'b0, 7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
      #1;
      check("reset flush", flush, 1'b0);
      check("reset redirect_pc", redirect_pc, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) apply(vecs[i], i);

      // Squash: a valid taken branch in the flush cycle must be ignored.
      @(negedge clk);
      drive_ex(1'b1, BR, 3'b000, 32'd9, 32'd9, 32'h324, 13'h008, 1'b0);
      #1;
      check("squash first ex_taken", ex_taken, 1'b1);
      @(posedge clk); #1;
      check("squash first flush", flush, 1'b1);
      check("squash first redirect_pc", redirect_pc, 32'h32C);
      check("squash first ctr", dut.bht[9], 2'b10);
      m_branches++; m_misp++;
      drive_ex(1'b1, BR, 3'b000, 32'd9, 32'd9, 32'h328, 13'h008, 1'b0);
      #1;
      check("squash wrong-path ex_taken", ex_taken, 1'b0);
      @(posedge clk); #1;
      check("squash no second flush", flush, 1'b0);
      check("squash redirect_pc held", redirect_pc, 32'h32C);
      check("squash ctr untouched", dut.bht[10], 2'b01);
      idle_cycle("squash");

      // Target wrap, then asynchronous reset while flush is high.
      @(negedge clk);
      drive_ex(1'b1, BR, 3'b000, 32'd4, 32'd4, 32'hFFFFFFF8, 13'h008, 1'b0);
      #1;
      check("wrap ex_taken", ex_taken, 1'b1);
      @(posedge clk); #1;
      m_branches++; m_misp++;
      check("wrap flush", flush, 1'b1);
      check("wrap redirect_pc", redirect_pc, 32'h0);
      check("wrap ctr", dut.bht[62], 2'b10);
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, m_branches);
      check("stat_mispredicts", stat_mispredicts, m_misp);
`endif
      drive_ex(1'b0, 7'd0, 3'd0, '0, '0, '0, '0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("midflush reset flush", flush, 1'b0);
      check("midflush reset redirect_pc", redirect_pc, 32'h0);
      begin
         int bad = 0;
         for (int i = 0; i < 64; i++) if (dut.bht[i] !== 2'b01) bad++;
         check("midflush reset bht entries off CTR_INIT", bad, 0);
      end
`ifdef BRANCH_STATS_EN
      check("reset stat_branches", stat_branches, 32'h0);
      check("reset stat_mispredicts", stat_mispredicts, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      if_valid = 1'b1; if_pc = 32'h220;
      #1;
      check("post-reset pred idx8", if_pred_taken, 1'b0);
      if_pc = 32'h100;
      #1;
      check("post-reset pred idx0", if_pred_taken, 1'b0);
      @(posedge clk); #1;
      check("post-reset flush idle", flush, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
